// File: rtl/ascon_core_driver.sv
// -----------------------------------------------------------------------------
// ascon_core_driver
//
// Purpose:
//   Host-facing sequencer for an Ascon AEAD core. A job follows these steps:
//     1. The host sends a command word. Bit 0 selects the mode
//        (0 = encrypt, 1 = decrypt).
//     2. The host then loads 16 words (encrypt) or 20 words (decrypt).
//        These fill key, nonce, AD, text and (decrypt only) the tag.
//     3. The block pulses core_start for one cycle.
//     4. It waits for core_done and captures the core results.
//     5. It streams the results back to the host, ending with a status word.
//   128-bit fields are packed big-endian by word: word 0 -> [127:96],
//   word 3 -> [31:0].
//
// Configuration:
//   ASCON_DRV_TIMEOUT_EN  When defined, WAIT gives up after TIMEOUT_CYCLES
//                         cycles without core_done. The block then returns
//                         zero result words and status bit1 = 1.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready/  host load stream (command word then payload words)
//   in_data[31:0]
//   out_valid/out_ready/ host result stream; out_last marks the status word
//   out_data[31:0]/out_last
//   busy                high whenever the block is not idle
//   core_start, core_mode[1:0], core_key/nonce/ad/text/tag_in[127:0]
//                       request side of the Ascon core
//   core_done, core_error, core_ciphertext/tag/plaintext[127:0]
//                       completion side of the Ascon core
//
// Status word: bit0 = core error (decrypt only), bit1 = timeout,
//              bit2 = mode, bits[31:3] = 0.
// -----------------------------------------------------------------------------
module ascon_core_driver #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         busy,
    output logic         core_start,
    output logic [1:0]   core_mode,
    output logic [127:0] core_key,
    output logic [127:0] core_nonce,
    output logic [127:0] core_ad,
    output logic [127:0] core_text,
    output logic [127:0] core_tag_in,
    input  logic         core_done,
    input  logic         core_error,
    input  logic [127:0] core_ciphertext,
    input  logic [127:0] core_tag,
    input  logic [127:0] core_plaintext
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UNLOAD = 3'd4
    } state_t;

    localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Value of the WAIT counter during the final permitted WAIT cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t         state_r;
    state_t         state_next_s;

    logic           in_ready_r;
    logic           out_valid_r;
    logic [31:0]    out_data_r;
    logic           out_last_r;
    logic           busy_r;
    logic           core_start_r;
    logic [1:0]     core_mode_r;
    logic [127:0]   core_key_r;
    logic [127:0]   core_nonce_r;
    logic [127:0]   core_ad_r;
    logic [127:0]   core_text_r;
    logic [127:0]   core_tag_in_r;

    logic [4:0]     load_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [3:0]     out_idx_r;
    logic [127:0]   res_ct_r;
    logic [127:0]   res_tag_r;
    logic [127:0]   res_pt_r;
    logic           res_err_r;
    logic           res_to_r;

    logic           mode_s;
    logic           in_fire_s;
    logic           out_fire_s;
    logic           load_last_s;
    logic [3:0]     out_last_idx_s;
    logic           timeout_hit_s;
    logic [6:0]     lane_s;
    logic [31:0]    status_s;

    // Pick word i (0 = most significant) of a 128-bit field.
    function automatic logic [31:0] field_word(input logic [127:0] v, input logic [1:0] i);
        logic [6:0] base;
        base = {~i, 5'd0};
        return v[base +: 32];
    endfunction

    // Result-stream word at position idx for the given mode, as {last, data}.
    function automatic logic [32:0] unload_word(
        input logic         mode,
        input logic [3:0]   idx,
        input logic [127:0] ct,
        input logic [127:0] tg,
        input logic [127:0] pt,
        input logic [31:0]  status
    );
        logic [32:0] w;
        w = 33'd0;
        if (mode) begin
            case (idx)
                4'd0, 4'd1, 4'd2, 4'd3: w = {1'b0, field_word(pt, idx[1:0])};
                4'd4:                   w = {1'b1, status};
                default:                w = 33'd0;
            endcase
        end else begin
            case (idx)
                4'd0, 4'd1, 4'd2, 4'd3: w = {1'b0, field_word(ct, idx[1:0])};
                4'd4, 4'd5, 4'd6, 4'd7: w = {1'b0, field_word(tg, idx[1:0])};
                4'd8:                   w = {1'b1, status};
                default:                w = 33'd0;
            endcase
        end
        return w;
    endfunction

    assign mode_s         = core_mode_r[0];
    assign in_fire_s      = in_valid & in_ready_r;
    assign out_fire_s     = out_valid_r & out_ready;
    assign load_last_s    = (load_cnt_r == (mode_s ? 5'd19 : 5'd15));
    assign out_last_idx_s = mode_s ? 4'd4 : 4'd8;
    // Bit offset of the word slot being loaded; word 0 of a field sits at the top.
    assign lane_s         = {~load_cnt_r[1:0], 5'd0};
    assign status_s       = {29'd0, mode_s, res_to_r, res_err_r};

`ifdef ASCON_DRV_TIMEOUT_EN
    assign timeout_hit_s  = (wait_cnt_r == WAIT_LAST);
`else
    assign timeout_hit_s  = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_fire_s) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_fire_s && load_last_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_START: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    state_next_s = ST_UNLOAD;
                end else if (timeout_hit_s) begin
                    state_next_s = ST_UNLOAD;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_UNLOAD: begin
                if (out_fire_s && (out_idx_r == out_last_idx_s)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_UNLOAD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Control outputs registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r   <= 1'b0;
            busy_r       <= 1'b0;
            core_start_r <= 1'b0;
        end else begin
            in_ready_r   <= (state_next_s == ST_IDLE) || (state_next_s == ST_LOAD);
            busy_r       <= (state_next_s != ST_IDLE);
            core_start_r <= (state_next_s == ST_START);
        end
    end

    // Command capture and payload loading. Core fields are written only here,
    // so they hold steady from START until the next job is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_mode_r   <= 2'd0;
            load_cnt_r    <= 5'd0;
            core_key_r    <= 128'd0;
            core_nonce_r  <= 128'd0;
            core_ad_r     <= 128'd0;
            core_text_r   <= 128'd0;
            core_tag_in_r <= 128'd0;
        end else if (in_fire_s && (state_r == ST_IDLE)) begin
            core_mode_r <= {1'b0, in_data[0]};
            load_cnt_r  <= 5'd0;
        end else if (in_fire_s && (state_r == ST_LOAD)) begin
            load_cnt_r <= load_cnt_r + 5'd1;
            case (load_cnt_r[4:2])
                3'd0:    core_key_r[lane_s +: 32]    <= in_data;
                3'd1:    core_nonce_r[lane_s +: 32]  <= in_data;
                3'd2:    core_ad_r[lane_s +: 32]     <= in_data;
                3'd3:    core_text_r[lane_s +: 32]   <= in_data;
                3'd4:    core_tag_in_r[lane_s +: 32] <= in_data;
                default: core_tag_in_r               <= core_tag_in_r;
            endcase
        end else begin
            load_cnt_r <= load_cnt_r;
        end
    end

    // WAIT cycle counter; it saturates so that it never wraps in long waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= '0;
        end else if (state_r == ST_START) begin
            wait_cnt_r <= '0;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != WAIT_LAST)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Result capture and the registered result stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_ct_r    <= 128'd0;
            res_tag_r   <= 128'd0;
            res_pt_r    <= 128'd0;
            res_err_r   <= 1'b0;
            res_to_r    <= 1'b0;
            out_idx_r   <= 4'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'd0;
            out_last_r  <= 1'b0;
        end else if ((state_r == ST_WAIT) && core_done) begin
            res_ct_r    <= core_ciphertext;
            res_tag_r   <= core_tag;
            res_pt_r    <= core_plaintext;
            // The error flag only means something for decrypt.
            res_err_r   <= core_error & mode_s;
            res_to_r    <= 1'b0;
            out_idx_r   <= 4'd0;
            out_valid_r <= 1'b1;
            // First word comes straight from the core; it is never the status word.
            {out_last_r, out_data_r} <= unload_word(mode_s, 4'd0, core_ciphertext,
                                                    core_tag, core_plaintext, 32'd0);
        end else if ((state_r == ST_WAIT) && timeout_hit_s) begin
            res_ct_r    <= 128'd0;
            res_tag_r   <= 128'd0;
            res_pt_r    <= 128'd0;
            res_err_r   <= 1'b0;
            res_to_r    <= 1'b1;
            out_idx_r   <= 4'd0;
            out_valid_r <= 1'b1;
            out_data_r  <= 32'd0;
            out_last_r  <= 1'b0;
        end else if ((state_r == ST_UNLOAD) && out_fire_s) begin
            if (out_idx_r == out_last_idx_s) begin
                out_valid_r <= 1'b0;
                out_data_r  <= 32'd0;
                out_last_r  <= 1'b0;
                out_idx_r   <= 4'd0;
            end else begin
                out_idx_r <= out_idx_r + 4'd1;
                {out_last_r, out_data_r} <= unload_word(mode_s, out_idx_r + 4'd1, res_ct_r,
                                                        res_tag_r, res_pt_r, status_s);
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_last    = out_last_r;
    assign busy        = busy_r;
    assign core_start  = core_start_r;
    assign core_mode   = core_mode_r;
    assign core_key    = core_key_r;
    assign core_nonce  = core_nonce_r;
    assign core_ad     = core_ad_r;
    assign core_text   = core_text_r;
    assign core_tag_in = core_tag_in_r;

endmodule

// File: doc/ascon_core_driver.md
ASCON_CORE_DRIVER -- requirements
Module: ascon_core_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, the maximum number of WAIT cycles before timeout (used only when ASCON_DRV_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1, in_data input 32: host load stream.
REQ-005 SHALL have ports out_valid output 1, out_ready input 1, out_data output 32, out_last output 1: host result stream.
REQ-006 SHALL have port busy  output  1  high in every state except IDLE.
REQ-007 SHALL have core-side outputs core_start 1, core_mode 2 (0 encrypt, 1 decrypt), and core_key, core_nonce, core_ad, core_text, core_tag_in, each 128.
REQ-008 SHALL have core-side inputs core_done 1, core_error 1, and core_ciphertext, core_tag, core_plaintext, each 128.
REQ-009 SHALL pack 128-bit fields with word 0 of a field at bits [127:96] and word 3 at bits [31:0].

Function
REQ-010 SHALL implement states IDLE, LOAD, START, WAIT, UNLOAD.
REQ-011 SHALL set in_ready=1 only in IDLE and LOAD; a word transfers when in_valid and in_ready are both high.
REQ-012 In IDLE, the transferred word SHALL be the command word: bit0 = mode (0 encrypt, 1 decrypt), bits [31:1] ignored; the block then enters LOAD with word counter 0.
REQ-013 In LOAD, encrypt SHALL accept 16 words (key 4, nonce 4, AD 4, plaintext 4 into core_text); decrypt SHALL accept 20 words (key, nonce, AD, ciphertext into core_text, tag into core_tag_in).
REQ-014 The last load word SHALL move the block to START on the next cycle; in_valid gaps SHALL stall the counter without losing data.
REQ-015 START SHALL drive core_start=1 for exactly one cycle, then enter WAIT; core_* data outputs SHALL remain stable from START until IDLE is re-entered.
REQ-016 In WAIT, the cycle core_done=1 SHALL capture core_ciphertext, core_tag, core_plaintext and core_error, then enter UNLOAD; core_done SHALL be ignored in all other states.
REQ-017 UNLOAD for encrypt SHALL emit 9 words: ciphertext 0-3, tag 0-3, status; for decrypt it SHALL emit 5 words: plaintext 0-3, status.
REQ-018 The status word SHALL be bit0 = captured core_error (always 0 for encrypt), bit1 = timeout, bit2 = mode, bits [31:3] = 0; out_last=1 only on the status word.
REQ-019 out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0; a word advances only on out_valid and out_ready both high.
REQ-020 Acceptance of the status word SHALL return the block to IDLE on the next cycle with out_valid=0; a new command is accepted no earlier than that cycle.
REQ-021 Minimum job latency SHALL be: command plus N load words, 1 START cycle, core latency plus 1 cycle, then 9 or 5 output words with out_ready held high.

Reset
REQ-022 rst SHALL asynchronously force IDLE and set in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, core_start=0, core_mode=0, all 128-bit core outputs 0, counters and captured results 0; in_ready rises on the first clock after rst deasserts.
REQ-023 rst asserted mid-job (any state) SHALL discard the job with no further core_start and no output words.

Configuration
REQ-024 With ASCON_DRV_TIMEOUT_EN defined, WAIT SHALL count cycles, and on reaching TIMEOUT_CYCLES with no core_done it SHALL enter UNLOAD with result words 0, status bit1=1 and bit0=0.
REQ-025 With ASCON_DRV_TIMEOUT_EN undefined, WAIT SHALL wait indefinitely for core_done, and status bit1 SHALL always be 0.

Verification
REQ-026 Encrypt job: command 0x0, 16 words with key=0x000102..0F and plaintext words 0x11111111 -> one core_start pulse, core_key=0x000102030405060708090A0B0C0D0E0F, 9 outputs, status=0x0 with out_last.
REQ-027 Decrypt job: command 0x1, 20 words; stub core returns core_error=1 -> 5 outputs, status=0x5.
REQ-028 Backpressure: out_ready toggled 1/0 every cycle during UNLOAD -> no duplicated or dropped words and out_data stable while stalled.
REQ-029 Timeout (macro defined, TIMEOUT_CYCLES=8, stub core never asserts done) -> UNLOAD after 8 WAIT cycles, zero result words, status=0x2 for encrypt.
REQ-030 rst pulsed during LOAD word 7 and again during WAIT -> IDLE, all outputs 0; a core_done pulse arriving after rst is ignored; the next job completes normally.
